// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus shared by the loader and its source.
// Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1; nothing else is consumed.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses LEN_HI, LEN_LO, 4*N data bytes, CHK and writes big-endian words to instruction memory.
// The processor is held in reset until a load completes with a matching checksum.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [2:0]   dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            state, state_nxt;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [7:0]        chk;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    // Only the three earlier bytes of a word need storing; the fourth arrives with the write.
    logic [23:0]       asm_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic              xfer;
    logic [15:0]       n_full;
    logic              len_big;
    logic              last_word;

    assign bus.in_ready  = (state == LEN_HI) || (state == LEN_LO) ||
                           (state == DATA)   || (state == CHECK);
    assign busy          = bus.in_ready;
    assign done          = (state == DONE);
    assign err           = (state == ERROR);
    assign cpu_reset     = (state == DONE);
    assign dbg_state     = state;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign n_full    = {len_hi, bus.in_data};
    assign len_big   = {1'b0, n_full} > DEPTH;
    assign last_word = (17'(word_cnt) + 17'd1) == {1'b0, len};

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = LEN_HI;
            LEN_HI:            if (xfer) state_nxt = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_big)            state_nxt = ERROR;
                    else if (n_full == '0)  state_nxt = CHECK;
                    else                    state_nxt = DATA;
                end
            end
            DATA:   if (xfer && byte_cnt == 2'd3 && last_word) state_nxt = CHECK;
            CHECK:  if (xfer) state_nxt = (bus.in_data == chk) ? DONE : ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            len_hi   <= '0;
            len      <= '0;
            chk      <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            asm_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        chk      <= '0;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                    end
                end
                LEN_HI: if (xfer) len_hi <= bus.in_data;
                LEN_LO: if (xfer) len <= n_full;
                DATA: begin
                    if (xfer) begin
                        asm_q    <= {asm_q[15:0], bus.in_data};
                        chk      <= chk ^ bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        // The write lands the cycle after the 4th byte, overlapping the next byte or CHECK entry.
                        if (byte_cnt == 2'd3) begin
                            we_q     <= 1'b1;
                            wdata_q  <= {asm_q, bus.in_data};
                            addr_q   <= word_cnt[ADDR_W-1:0];
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the writer side of the processor's instruction ROM.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into instruction memory at consecutive word addresses from 0, then verifies a checksum.
- Holds the processor in reset for the whole load and releases it only after a successful load.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; ignored while a load is in progress.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  word to write.
- cpu_reset  output  1  active-low reset to the datapath; 0 holds the processor.
- busy  output  1  load in progress.
- done  output  1  last load succeeded; sticky until the next start.
- err  output  1  last load failed; sticky until the next start.

Behaviour:
- Transfer rule: a byte transfers when in_valid and in_ready are both 1 at a rising edge. No other byte is consumed.
- Frame format: LEN_HI, LEN_LO (N = 16-bit word count), then 4*N data bytes (MSB first per word), then CHK.
- CHK = XOR of all 4*N data bytes. Length bytes are excluded. N=0 gives an expected CHK of 0x00.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- Reset (reset=0 at an edge) enters IDLE and sets all outputs to 0: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=0, busy=0, done=0, err=0. The checksum register, byte counter and word counter clear.
- Reset mid-load aborts the load immediately. Partially written memory is left as-is.
- IDLE, DONE, ERROR: on start=1, go to LEN_HI. Clear done, err, checksum and counters; set cpu_reset=0 and busy=1 from the next cycle.
- LEN_HI: accept one byte into N[15:8] -> LEN_LO.
- LEN_LO: accept one byte into N[7:0].
  - If N > DEPTH -> ERROR.
  - Else if N == 0 -> CHECK.
  - Else -> DATA.
  - The N > DEPTH check uses the complete 16-bit value.
- DATA:
  - Each accepted byte shifts into a 32-bit assembly register (new byte into bits [7:0]) and is XORed into the checksum.
  - On the 4th byte of a word, next cycle: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = word index (0,1,2,...).
  - After word N-1 is accepted -> CHECK.
  - in_ready stays 1 through the imem_we cycle. Back-to-back bytes every cycle are supported with no stall.
- imem_addr wrap: impossible by construction (N <= DEPTH). The word counter is ADDR_W+1 bits wide so N = DEPTH is representable.
- CHECK: accept one byte.
  - Equal to checksum -> DONE.
  - Else -> ERROR.
  - If the final data word's imem_we cycle coincides with CHECK entry, the write still completes.
- in_ready = 1 only in LEN_HI, LEN_LO, DATA, CHECK. It is registered (a function of state only), with no combinational path from in_valid.
- busy = 1 in LEN_HI, LEN_LO, DATA, CHECK.
- DONE: done=1, cpu_reset=1 (processor runs), in_ready=0.
- ERROR: err=1, cpu_reset stays 0, in_ready=0.
- done and err are never 1 simultaneously.
- start during a busy state is ignored and has no effect on the frame.
- in_valid with in_ready=0 is ignored; the byte is not consumed.
- imem_wdata holds its last value when imem_we=0. imem_addr holds the last written address.

Test Plan:
- Reset low 2 cycles, then release -> all outputs 0, state IDLE; in_valid=1 with data ignored.
- start, then bytes 00 02 | 20 08 00 05 | 00 00 00 0C | CHK=0x21, one per cycle -> imem_we pulses twice: addr0=0x20080005, addr1=0x0000000C. Then done=1, cpu_reset=1, err=0.
- Same frame with CHK=0x22 -> both words written, then err=1, done=0, cpu_reset stays 0.
- start, bytes 01 01 with ADDR_W=8 (N=257>256) -> ERROR right after LEN_LO, no imem_we. start again with 00 00 00 -> done=1.
- Valid frame with in_valid toggled randomly and start pulsed mid-DATA -> identical memory contents and result as the gap-free case; the start pulse is ignored.
- reset=0 asserted after 5 data bytes, then a fresh full load of 1 word -> outputs 0 on reset. New load writes addr0 with the correct word; done=1.
